// File: rtl/rip_lsu.sv
// rip_lsu: single-outstanding RV32I load/store unit driving MMU data port 1.
// Generates lane byte-enables/replicated store data and extends returned load data.
module rip_lsu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [3:0]            mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    store_q;
    logic [2:0]              f3_q;
    logic [1:0]              off_q;
    logic [3:0]              be_q;
    logic                    accept;
    logic                    illegal;
    logic [3:0]              be_c;
    logic [DATA_WIDTH-1:0]   din_c;
    logic [DATA_WIDTH-1:0]   ld_shift;
    logic [DATA_WIDTH-1:0]   ld_data;

    // Request decode: legality, byte-enables and lane-replicated store data.
    always_comb begin
        illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
               || (req_store && (req_funct3 > 3'd2))
               || ((req_funct3[1:0] == 2'd1) && req_addr[0])
               || ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'd0));
        case (req_funct3[1:0])
            2'd0: begin
                be_c  = 4'b0001 << req_addr[1:0];
                din_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_c  = 4'b0011 << req_addr[1:0];
                din_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c  = 4'b1111;
                din_c = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = mem_dout >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    ld_data = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            3'd4:    ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
            3'd1:    ld_data = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            3'd5:    ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = mem_dout;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        mem_we    = '0;
        mem_re    = 1'b0;
        case (state_q)
            IDLE: begin
                // Blocking on mem_busy lets a transaction orphaned by reset drain first.
                req_ready = !mem_busy;
                if (req_valid && !mem_busy) begin
                    accept = 1'b1;
                    if (!illegal) state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_re  = !store_q;
                mem_we  = store_q ? be_q : 4'b0000;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: state_d = WAIT_DONE;
            WAIT_DONE: if (!mem_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            be_q       <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (accept) begin
                if (illegal) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else begin
                    store_q  <= req_store;
                    f3_q     <= req_funct3;
                    off_q    <= req_addr[1:0];
                    be_q     <= be_c;
                    mem_addr <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                    mem_din  <= din_c;
                end
            end
            if ((state_q == WAIT_DONE) && !mem_busy) begin
                resp_valid <= 1'b1;
                resp_rdata <= store_q ? '0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_rip_lsu.sv
// Self-checking bench for rip_lsu: variable-latency MMU fixture plus a byte-level reference model.
module tb_rip_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = '0;
    logic        mem_busy;

    rip_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MMU fixture: a word array, busy for mmu_lat cycles after a request.
    bit [31:0] mmu_mem [64];
    int        mmu_lat = 3;
    int        mmu_cnt = 0;
    logic [31:0] mmu_rd = '0;
    assign mem_busy = (mmu_cnt != 0);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r = old;
        for (int l = 0; l < 4; l++) if (we[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mmu_cnt != 0) begin
            mmu_cnt <= mmu_cnt - 1;
            if (mmu_cnt == 1) mem_dout <= mmu_rd;
        end else if (mem_re || (mem_we != 4'b0000)) begin
            mmu_cnt <= mmu_lat;
            mmu_rd  <= mmu_mem[mem_addr[7:2]];
            mmu_mem[mem_addr[7:2]] <= merge(mmu_mem[mem_addr[7:2]], mem_din, mem_we);
            mem_dout <= $urandom;
        end
    end

    // Output monitor.
    typedef struct { int c; logic e; logic [31:0] d; } resp_t;
    resp_t rq [$];
    int re_hi = 0, we_hi = 0, re_wide = 0, we_wide = 0, resp_double = 0;
    logic prev_re = 1'b0, prev_we = 1'b0, prev_rv = 1'b0;
    logic [3:0]  we_val = '0;
    logic [31:0] we_din = '0, we_addr = '0, re_addr = '0;

    always @(negedge clk) begin
        if (mem_re) begin re_hi <= re_hi + 1; re_addr <= mem_addr; end
        if (mem_we != 4'b0000) begin
            we_hi <= we_hi + 1; we_val <= mem_we; we_din <= mem_din; we_addr <= mem_addr;
        end
        if (mem_re && prev_re) re_wide <= re_wide + 1;
        if ((mem_we != 4'b0000) && prev_we) we_wide <= we_wide + 1;
        if (resp_valid) begin
            rq.push_back('{c: cyc, e: resp_err, d: resp_rdata});
            if (prev_rv) resp_double <= resp_double + 1;
        end
        prev_re <= mem_re;
        prev_we <= (mem_we != 4'b0000);
        prev_rv <= resp_valid;
    end

    // Reference model: byte-addressed memory and RV32I access rules.
    bit [7:0] ref_mem [256];
    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit illegal_f(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int n = 1 << f3[1:0];
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (st && f3 > 2) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int n = 1 << f3[1:0];
        logic [3:0] be = '0;
        for (int i = 0; i < n; i++) be[(a + i) % 4] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_din(input logic [2:0] f3, input logic [31:0] wd);
        int n = 1 << f3[1:0];
        logic [31:0] d = '0;
        for (int l = 0; l < 4; l++) d[8*l +: 8] = wd[8*(l % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a);
        int n = 1 << f3[1:0];
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 256]) << (8 * i));
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int acc);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        chk("accept_wait", 32'(k < 50), 32'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int rc, output logic e, output logic [31:0] d);
        int k = 0;
        while (rq.size() == 0 && k < 40) begin @(negedge clk); k++; end
        if (rq.size() == 0) begin
            chk("resp_timeout", 32'(rq.size()), 32'd1);
            rc = -1; e = 1'bx; d = 'x;
        end else begin
            rc = rq[0].c; e = rq[0].e; d = rq[0].d;
            void'(rq.pop_front());
        end
    endtask

    task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
        int re0 = re_hi, we0 = we_hi, acc, rc, n;
        bit ill;
        logic e;
        logic [31:0] d, er;
        ill = illegal_f(st, f3, a);
        er = (!st && !ill) ? load_ref(f3, a) : 32'd0;
        n = 1 << f3[1:0];
        if (st && !ill) for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
        present(st, f3, a, wd, acc);
        wait_resp(rc, e, d);
        @(negedge clk);
        chk("latency", rc - acc, ill ? 1 : 3 + mmu_lat);
        chk("resp_err", 32'(e), 32'(ill));
        chk("resp_rdata", d, er);
        chk("re_pulses", re_hi - re0, 32'(!st && !ill));
        chk("we_pulses", we_hi - we0, 32'(st && !ill));
        chk("extra_resp", 32'(rq.size()), 32'd0);
        if (st && !ill) begin
            chk("mem_we", 32'(we_val), 32'(exp_be(f3, a)));
            chk("mem_din", we_din, exp_din(f3, wd));
            chk("mem_addr_st", we_addr, {a[31:2], 2'b00});
        end
        if (!st && !ill) chk("mem_addr_ld", re_addr, {a[31:2], 2'b00});
    endtask

    initial begin
        int acc, rc, re0, k;
        int accs [4];
        int rcs [4];
        logic [31:0] exps [4];
        logic [31:0] a, d;
        logic e;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed sequence.
        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        xact(1'b0, 3'd2, 32'h10, 32'h0);
        xact(1'b1, 3'd0, 32'h13, 32'h000000A5);
        xact(1'b0, 3'd0, 32'h13, 32'h0);
        xact(1'b0, 3'd4, 32'h13, 32'h0);
        xact(1'b1, 3'd1, 32'h22, 32'h00008001);
        xact(1'b0, 3'd1, 32'h22, 32'h0);
        xact(1'b0, 3'd5, 32'h22, 32'h0);
        xact(1'b0, 3'd2, 32'h20, 32'h0);
        xact(1'b0, 3'd2, 32'h11, 32'h0);
        xact(1'b1, 3'd1, 32'h03, 32'h1234);
        xact(1'b0, 3'd3, 32'h40, 32'h0);
        xact(1'b1, 3'd4, 32'h40, 32'h55);

        // Four loads with req_valid held high throughout.
        mmu_lat = 3;
        re0 = re_hi;
        @(negedge clk);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(0, 63)) * 4;
            req_store = 1'b0; req_funct3 = 3'd2; req_addr = a;
            exps[i] = load_ref(3'd2, a);
            k = 0;
            while (!req_ready && k < 50) begin @(negedge clk); k++; end
            chk("bb_accept_wait", 32'(k < 50), 32'd1);
            accs[i] = cyc;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_resp(rcs[i], e, d);
            chk("bb_latency", rcs[i] - accs[i], 32'd6);
            chk("bb_rdata", d, exps[i]);
            if (i > 0) chk("bb_spacing", rcs[i] - rcs[i-1], 32'd6);
        end
        @(negedge clk);
        chk("bb_re_pulses", re_hi - re0, 32'd4);

        // Reset while a load sits in WAIT_DONE.
        present(1'b0, 3'd2, 32'h10, 32'h0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_mem_we", 32'(mem_we), 32'd0);
        chk("mr_mem_re", 32'(mem_re), 32'd0);
        chk("mr_mem_addr", mem_addr, 32'd0);
        chk("mr_mem_din", mem_din, 32'd0);
        chk("mr_resp_valid", 32'(resp_valid), 32'd0);
        chk("mr_resp_err", 32'(resp_err), 32'd0);
        chk("mr_resp_rdata", resp_rdata, 32'd0);
        k = 0;
        while (mem_busy && k < 20) begin
            chk("mr_ready_while_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        chk("mr_ready_after_drain", 32'(req_ready), 32'd1);
        repeat (8) @(negedge clk);
        chk("mr_no_resp", 32'(rq.size()), 32'd0);
        xact(1'b1, 3'd2, 32'h30, 32'hCAFEF00D);
        xact(1'b0, 3'd2, 32'h30, 32'h0);

        // Randomized traffic with variable MMU latency.
        for (int i = 0; i < 80; i++) begin
            logic st;
            logic [2:0] f3;
            mmu_lat = $urandom_range(1, 4);
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            xact(st, f3, a, $urandom);
        end

        chk("resp_single_cycle", 32'(resp_double), 32'd0);
        chk("re_single_cycle", 32'(re_wide), 32'd0);
        chk("we_single_cycle", 32'(we_wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
